// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and constants for the controller read-return path
package ddr_pkg;
    localparam int TS_W      = 8;
    localparam int BL8_PAIRS = 4;
    localparam int BC4_PAIRS = 2;
    typedef struct packed {
        logic [TS_W-1:0] due;
        logic            bl8;
    } rd_q_entry_t;
    typedef enum logic {IDLE, CAP} rd_cap_state_e;
endpackage

// File: rtl/rd_lat_fifo.sv
// rd_lat_fifo: circular queue of in-flight reads awaiting their due timestamp
module rd_lat_fifo import ddr_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                     CK_t,
    input  logic                     reset_n,
    input  logic                     push,
    input  rd_q_entry_t              din,
    input  logic                     pop,
    output rd_q_entry_t              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    rd_q_entry_t r_mem [DEPTH];
    logic [AW:0] r_wp, r_rp;
    always_ff @(posedge CK_t or negedge reset_n)
        if (!reset_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (push) r_wp <= r_wp + 1'b1;
            if (pop) r_rp <= r_rp + 1'b1;
        end
    always_ff @(posedge CK_t)
        if (push) r_mem[r_wp[AW-1:0]] <= din;
    assign head  = r_mem[r_rp[AW-1:0]];
    assign empty = r_wp == r_rp;
    assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign count = r_wp - r_rp;
endmodule

// File: rtl/rd_data_capture.sv
// rd_data_capture: tracks READs through RL, captures DQ beat pairs, delivers one burst word per read.
// Optional RD_DBI_EN: beats with dbi_n low are stored inverted.
module rd_data_capture import ddr_pkg::*; #(
    parameter int RD_Q_DEPTH = 4
) (
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic        rd_cmd,
    input  logic        rd_bl8,
    input  logic [5:0]  rl,
    input  logic [7:0]  dq_rise,
    input  logic [7:0]  dq_fall,
    input  logic        dbi_n_rise,
    input  logic        dbi_n_fall,
    output logic        rd_valid,
    output logic [63:0] rd_data,
    output logic        rd_data_bl8,
    output logic        busy,
    output logic        ovf_err,
    output logic        col_err
);
    localparam int AW = $clog2(RD_Q_DEPTH);
    rd_cap_state_e   r_state, w_state_nxt;
    logic [TS_W-1:0] r_ts;
    logic [1:0]      r_cnt;
    logic            r_bl8, r_valid, r_data_bl8, r_ovf, r_col;
    logic [63:0]     r_asm, r_data;
    logic [7:0]      w_rise, w_fall;
    logic [15:0]     w_pair;
    logic [63:0]     w_shift;
    rd_q_entry_t     w_head, w_entry;
    logic            w_q_full, w_empty, w_full, w_hit, w_push, w_start, w_last;
    logic [AW:0]     w_count;
`ifdef RD_DBI_EN
    assign w_rise = dbi_n_rise ? dq_rise : ~dq_rise;
    assign w_fall = dbi_n_fall ? dq_fall : ~dq_fall;
`else
    logic w_unused_dbi;
    assign w_unused_dbi = dbi_n_rise ^ dbi_n_fall;
    assign w_rise = dq_rise;
    assign w_fall = dq_fall;
`endif
    assign w_pair  = {w_fall, w_rise};
    assign w_shift = {w_pair, r_asm[63:16]};
    assign w_entry = '{due: r_ts + {{(TS_W-6){1'b0}}, rl}, bl8: rd_bl8};
    // Head leaves the FIFO when it falls due; the burst being captured still holds a slot.
    assign w_hit   = !w_empty && w_head.due == r_ts;
    assign w_full  = w_q_full || (r_state == CAP && w_count == (AW+1)'(RD_Q_DEPTH - 1));
    assign w_push  = rd_cmd && !w_full;
    assign w_start = r_state == IDLE && w_hit;
    assign w_last  = r_state == CAP && r_cnt == 2'd1;
    rd_lat_fifo #(.DEPTH(RD_Q_DEPTH)) u_fifo (
        .CK_t    (CK_t),
        .reset_n (reset_n),
        .push    (w_push),
        .din     (w_entry),
        .pop     (w_hit),
        .head    (w_head),
        .full    (w_q_full),
        .empty   (w_empty),
        .count   (w_count)
    );
    always_ff @(posedge CK_t or negedge reset_n)
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_state_nxt;
    always_comb begin
        w_state_nxt = w_start ? CAP : w_last ? IDLE : r_state;
    end
    always_ff @(posedge CK_t or negedge reset_n)
        if (!reset_n) begin
            r_ts       <= '0;
            r_cnt      <= '0;
            r_bl8      <= 1'b0;
            r_asm      <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_data_bl8 <= 1'b0;
            r_ovf      <= 1'b0;
            r_col      <= 1'b0;
        end else begin
            r_ts    <= r_ts + 1'b1;
            r_valid <= w_last;
            r_ovf   <= r_ovf | (rd_cmd & w_full);
            r_col   <= r_col | (r_state == CAP && w_hit);
            // Pairs shift in from the top so beat 0 lands in [7:0] once the burst is complete.
            if (w_start) begin
                r_asm <= {w_pair, 48'h0};
                r_cnt <= w_head.bl8 ? 2'(BL8_PAIRS - 1) : 2'(BC4_PAIRS - 1);
                r_bl8 <= w_head.bl8;
            end else if (r_state == CAP) begin
                r_asm <= w_shift;
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last) begin
                r_data     <= r_bl8 ? w_shift : {32'h0, w_shift[63:32]};
                r_data_bl8 <= r_bl8;
            end
        end
    assign rd_valid    = r_valid;
    assign rd_data     = r_data;
    assign rd_data_bl8 = r_data_bl8;
    assign busy        = !w_empty || r_state != IDLE;
    assign ovf_err     = r_ovf;
    assign col_err     = r_col;
endmodule
